motor_pwm_generator: RTL and testbench

Converts one motor's 16-bit `motor_rate` (produced by `motor_rate_calculator`) into a standard ESC servo pulse train. It contains a microsecond prescaler, a fixed-period frame counter and a shadow register, so pulse widths only change on frame boundaries and never glitch. An arming state machine and a stale-input watchdog force a minimum (motor-idle) pulse whenever the vehicle is not safely armed. One instance sits between each `motor_rate_calculator` output and its ESC pin.

---
 rtl/motor_pwm_generator.sv | 227 ++++++++++++++++++++++
 tb/tb_motor_pwm_generator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pwm_generator
//  Purpose  : Turns one motor's rate command into an ESC servo pulse train.
//             A microsecond prescaler drives a fixed-period frame counter.
//             Pulse widths come from a shadow register that is only loaded
//             on frame boundaries, so a frame never changes width part-way.
//             An arming FSM and a stale-input watchdog force the idle pulse
//             whenever the vehicle is not safely armed.
//  Ports    : sys_clk      - system clock
//             rst_n        - asynchronous active-low reset
//             motor_rate   - commanded rate
//             rate_valid   - one-cycle strobe, motor_rate is new
//             arm_req      - level, high requests arming
//             pwm_out      - ESC pulse
//             frame_start  - one-cycle pulse at the start of each frame
//             armed        - high only in ARMED
//             failsafe     - high only in FAILSAFE
//             active_pulse - pulse width (ticks) of the current frame
//  Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_generator #(
    parameter int MOTOR_RATE_BIT_WIDTH = 16,
    parameter int TICK_DIV             = 38,
    parameter int PERIOD_TICKS         = 20000,
    parameter int MIN_PULSE            = 1000,
    parameter int MAX_PULSE            = 2000,
    parameter int RATE_SHIFT           = 6,
    parameter int ARM_FRAMES           = 50,
    parameter int TIMEOUT_FRAMES       = 10
) (
    input  logic                            sys_clk,
    input  logic                            rst_n,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_rate,
    input  logic                            rate_valid,
    input  logic                            arm_req,
    output logic                            pwm_out,
    output logic                            frame_start,
    output logic                            armed,
    output logic                            failsafe,
    output logic [15:0]                     active_pulse
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ARM_W   = $clog2(ARM_FRAMES + 1);
    localparam int WD_W    = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0]        FC_LAST    = 16'(PERIOD_TICKS - 1);
    localparam logic [15:0]        MIN_W      = 16'(MIN_PULSE);
    localparam logic [15:0]        MAX_W      = 16'(MAX_PULSE);
    localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_FRAMES - 1);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;
    logic [15:0]        fc_q;
    logic               pwm_out_q;
    logic               frame_start_q;
    state_t             state_q;
    logic [ARM_W-1:0]   arm_cnt_q;
    logic [WD_W-1:0]    wdog_q;
    logic [15:0]        pending_q;
    logic [15:0]        active_q;
    logic               armed_q;
    logic               failsafe_q;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic tick;
    logic boundary;

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (fc_q == FC_LAST);

    // ------------------------------------------------------------------
    // Width calculation: the sum is kept 17 bits wide so a full-scale
    // rate cannot wrap before saturation.
    // ------------------------------------------------------------------
    logic [MOTOR_RATE_BIT_WIDTH-1:0] rate_scaled;
    logic [16:0]                     width_sum;
    logic [15:0]                     width_d;

    assign rate_scaled = motor_rate >> RATE_SHIFT;
    assign width_sum   = 17'(MIN_PULSE) + 17'(rate_scaled);
    assign width_d     = (width_sum > {1'b0, MAX_W}) ? MAX_W : width_sum[15:0];

    // ------------------------------------------------------------------
    // Prescaler, frame counter and pulse output
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            fc_q          <= '0;
            pwm_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (tick) begin
                presc_q <= '0;
                if (fc_q == FC_LAST) begin
                    fc_q <= '0;
                end else begin
                    fc_q <= fc_q + 16'd1;
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            // Registered compare: the pulse lags fc by one cycle, which
            // keeps the high time an exact multiple of the tick length.
            pwm_out_q     <= (fc_q < active_q);
            frame_start_q <= boundary;
        end
    end

    // ------------------------------------------------------------------
    // Arming / watchdog state machine with the shadow width registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DISARMED;
            arm_cnt_q  <= '0;
            wdog_q     <= '0;
            pending_q  <= MIN_W;
            active_q   <= MIN_W;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (boundary) begin
                        active_q <= MIN_W;
                    end
                    if (arm_req) begin
                        state_q   <= ST_ARMING;
                        arm_cnt_q <= '0;
                    end
                end

                ST_ARMING: begin
                    if (boundary) begin
                        active_q <= MIN_W;
                    end
                    if (!arm_req) begin
                        state_q <= ST_DISARMED;
                    end else if (boundary) begin
                        if (arm_cnt_q == ARM_LAST) begin
                            state_q   <= ST_ARMED;
                            armed_q   <= 1'b1;
                            pending_q <= MIN_W;
                            wdog_q    <= '0;
                            arm_cnt_q <= '0;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + 1'b1;
                        end
                    end
                end

                ST_ARMED: begin
                    if (!arm_req) begin
                        // Dropping the request wins over a coincident boundary.
                        state_q <= ST_DISARMED;
                        armed_q <= 1'b0;
                        if (boundary) begin
                            active_q <= MIN_W;
                        end
                    end else begin
                        if (rate_valid) begin
                            pending_q <= width_d;
                            wdog_q    <= '0;
                        end
                        if (boundary) begin
                            // A strobe on the boundary cycle refreshes the
                            // watchdog; the frame still takes the old pending.
                            if (!rate_valid && (wdog_q == WD_LAST)) begin
                                state_q    <= ST_FAILSAFE;
                                armed_q    <= 1'b0;
                                failsafe_q <= 1'b1;
                                active_q   <= MIN_W;
                                wdog_q     <= '0;
                            end else begin
                                active_q <= pending_q;
                                if (!rate_valid) begin
                                    wdog_q <= wdog_q + 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_FAILSAFE: begin
                    if (boundary) begin
                        active_q <= MIN_W;
                    end
                    if (!arm_req) begin
                        state_q    <= ST_DISARMED;
                        failsafe_q <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= ST_DISARMED;
                    armed_q    <= 1'b0;
                    failsafe_q <= 1'b0;
                    active_q   <= MIN_W;
                end
            endcase
        end
    end

    assign pwm_out      = pwm_out_q;
    assign frame_start  = frame_start_q;
    assign armed        = armed_q;
    assign failsafe     = failsafe_q;
    assign active_pulse = active_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_pwm_generator
//  Purpose  : Directed self-checking bench for motor_pwm_generator using a
//             small parameter set (2-cycle tick, 40-tick frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_generator;

    logic        sys_clk;
    logic        rst_n;
    logic [15:0] motor_rate;
    logic        rate_valid;
    logic        arm_req;
    logic        pwm_out;
    logic        frame_start;
    logic        armed;
    logic        failsafe;
    logic [15:0] active_pulse;

    int tests_run;
    int tests_failed;

    motor_pwm_generator #(
        .MOTOR_RATE_BIT_WIDTH (16),
        .TICK_DIV             (2),
        .PERIOD_TICKS         (40),
        .MIN_PULSE            (10),
        .MAX_PULSE            (20),
        .RATE_SHIFT           (12),
        .ARM_FRAMES           (2),
        .TIMEOUT_FRAMES       (3)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .motor_rate   (motor_rate),
        .rate_valid   (rate_valid),
        .arm_req      (arm_req),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .armed        (armed),
        .failsafe     (failsafe),
        .active_pulse (active_pulse)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Wait (bounded) for the negedge on which frame_start is high.
    task automatic wait_fs(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: frame_start not seen within 400 cycles", name);
        end
    endtask

    // Count pwm high cycles and cycles up to the next frame_start.
    task automatic measure_frame(output int high, output int len, output bit changed);
        logic [15:0] a0;
        a0      = active_pulse;
        high    = 0;
        len     = -1;
        changed = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge sys_clk);
            if (pwm_out === 1'b1) high++;
            if (frame_start === 1'b1) begin
                len = i;
                break;
            end
            if (active_pulse !== a0) changed = 1'b1;
        end
    endtask

    task automatic pulse_rate(input logic [15:0] r);
        motor_rate = r;
        rate_valid = 1'b1;
        @(negedge sys_clk);
        rate_valid = 1'b0;
    endtask

    task automatic test_reset();
        int  h, l;
        bit  c;
        rst_n      = 1'b0;
        arm_req    = 1'b0;
        rate_valid = 1'b0;
        motor_rate = 16'h0000;
        #23;
        tests_run++;
        if ({pwm_out, frame_start, armed, failsafe} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {pwm_out, frame_start, armed, failsafe});
        end
        tests_run++;
        if (active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL reset_active: got %0d expected 10", active_pulse);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            measure_frame(h, l, c);
            tests_run++;
            if (h != 20 || l != 80 || c) begin
                tests_failed++;
                $display("FAIL disarmed_frame%0d: high=%0d len=%0d chg=%0b expected 20/80/0", f, h, l, c);
            end
        end
        tests_run++;
        if (armed !== 1'b0 || active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL disarmed_state: armed=%0b active=%0d expected 0/10", armed, active_pulse);
        end
    endtask

    task automatic test_arming();
        int h, l;
        bit c;
        arm_req = 1'b1;
        wait_fs("arm_b1");
        tests_run++;
        if (armed !== 1'b0 || active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL arm_first_boundary: armed=%0b active=%0d expected 0/10", armed, active_pulse);
        end
        wait_fs("arm_b2");
        tests_run++;
        if (armed !== 1'b1 || failsafe !== 1'b0) begin
            tests_failed++;
            $display("FAIL arm_second_boundary: armed=%0b failsafe=%0b expected 1/0", armed, failsafe);
        end
        repeat (2) @(negedge sys_clk);
        pulse_rate(16'h5000);
        tests_run++;
        if (active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL arm_no_midframe: got %0d expected 10", active_pulse);
        end
        wait_fs("arm_rate");
        tests_run++;
        if (active_pulse !== 16'd15) begin
            tests_failed++;
            $display("FAIL arm_width: got %0d expected 15", active_pulse);
        end
        measure_frame(h, l, c);
        tests_run++;
        if (h != 30 || l != 80 || c) begin
            tests_failed++;
            $display("FAIL arm_frame: high=%0d len=%0d chg=%0b expected 30/80/0", h, l, c);
        end
    endtask

    task automatic test_saturation();
        repeat (2) @(negedge sys_clk);
        pulse_rate(16'hFFFF);
        wait_fs("sat_max");
        tests_run++;
        if (active_pulse !== 16'd20) begin
            tests_failed++;
            $display("FAIL sat_max: got %0d expected 20", active_pulse);
        end
        repeat (2) @(negedge sys_clk);
        pulse_rate(16'h0000);
        wait_fs("sat_zero");
        tests_run++;
        if (active_pulse !== 16'd10 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_zero: active=%0d armed=%0b expected 10/1", active_pulse, armed);
        end
    endtask

    task automatic test_back_to_back();
        int h, l;
        bit c;
        // Entry: on the frame_start negedge (offset 0).
        repeat (20) @(negedge sys_clk);
        pulse_rate(16'h3000);                  // now at offset 21
        repeat (57) @(negedge sys_clk);        // offset 78
        tests_run++;
        if (active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL b2b_midframe: got %0d expected 10", active_pulse);
        end
        @(negedge sys_clk);                    // offset 79: boundary cycle
        motor_rate = 16'h8000;
        rate_valid = 1'b1;
        @(negedge sys_clk);                    // offset 80
        rate_valid = 1'b0;
        tests_run++;
        if (frame_start !== 1'b1 || active_pulse !== 16'd13) begin
            tests_failed++;
            $display("FAIL b2b_old_pending: fs=%0b active=%0d expected 1/13", frame_start, active_pulse);
        end
        measure_frame(h, l, c);
        tests_run++;
        if (h != 26 || l != 80 || c) begin
            tests_failed++;
            $display("FAIL b2b_frame13: high=%0d len=%0d chg=%0b expected 26/80/0", h, l, c);
        end
        tests_run++;
        if (active_pulse !== 16'd18) begin
            tests_failed++;
            $display("FAIL b2b_new_pending: got %0d expected 18", active_pulse);
        end
        measure_frame(h, l, c);
        tests_run++;
        if (h != 36 || l != 80 || c) begin
            tests_failed++;
            $display("FAIL b2b_frame18: high=%0d len=%0d chg=%0b expected 36/80/0", h, l, c);
        end
    endtask

    task automatic test_failsafe();
        repeat (2) @(negedge sys_clk);
        pulse_rate(16'h0000);
        wait_fs("fs_b1");
        wait_fs("fs_b2");
        tests_run++;
        if (armed !== 1'b1 || failsafe !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_before_timeout: armed=%0b failsafe=%0b expected 1/0", armed, failsafe);
        end
        wait_fs("fs_b3");
        tests_run++;
        if (failsafe !== 1'b1 || armed !== 1'b0 || active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL fs_entry: failsafe=%0b armed=%0b active=%0d expected 1/0/10", failsafe, armed, active_pulse);
        end
        repeat (3) @(negedge sys_clk);
        pulse_rate(16'hFFFF);
        wait_fs("fs_ignore");
        tests_run++;
        if (active_pulse !== 16'd10 || failsafe !== 1'b1) begin
            tests_failed++;
            $display("FAIL fs_ignore_rate: active=%0d failsafe=%0b expected 10/1", active_pulse, failsafe);
        end
        arm_req = 1'b0;
        @(negedge sys_clk);
        tests_run++;
        if (failsafe !== 1'b0 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_exit: failsafe=%0b armed=%0b expected 0/0", failsafe, armed);
        end
    endtask

    task automatic test_reset_midframe();
        int h, l;
        bit c;
        arm_req = 1'b1;
        wait_fs("rst_arm1");
        wait_fs("rst_arm2");
        repeat (2) @(negedge sys_clk);
        pulse_rate(16'h8000);
        wait_fs("rst_w18");
        tests_run++;
        if (active_pulse !== 16'd18 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_width: active=%0d armed=%0b expected 18/1", active_pulse, armed);
        end
        repeat (5) @(negedge sys_clk);
        tests_run++;
        if (pwm_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_pwm: got %0b expected 1", pwm_out);
        end
        rst_n   = 1'b0;
        arm_req = 1'b0;
        #1;
        tests_run++;
        if ({pwm_out, frame_start, armed, failsafe} !== 4'b0000 || active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL rst_async: flags=%b active=%0d expected 0000/10",
                     {pwm_out, frame_start, armed, failsafe}, active_pulse);
        end
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        measure_frame(h, l, c);
        tests_run++;
        if (h != 20 || l != 80 || armed !== 1'b0 || active_pulse !== 16'd10) begin
            tests_failed++;
            $display("FAIL rst_after_release: high=%0d len=%0d armed=%0b active=%0d expected 20/80/0/10",
                     h, l, armed, active_pulse);
        end
        @(negedge sys_clk);
        tests_run++;
        if (frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_single_cycle: got %0b expected 0", frame_start);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_arming();
        test_saturation();
        test_back_to_back();
        test_failsafe();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
